// File: rtl/qcw_burst_sequencer.sv
// Burst sequencer for the QCW phase-locked bridge driver: arms on a trigger, starts the
// driver, ramps phase_shift per driver cycle, drains, enforces an off-time and latches faults.
module qcw_burst_sequencer #(
    parameter int unsigned HOLDOFF_CYCLES  = 500000,
    parameter int unsigned DRAIN_CYCLES    = 2000,
    parameter int unsigned WATCHDOG_CYCLES = 4000,
    parameter logic [23:0] REP_PERIOD      = 24'd2000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        trig_ext_sel,
    input  logic        ext_trigger,
    input  logic [15:0] burst_cycles,
    input  logic [7:0]  ramp_start,
    input  logic [7:0]  ramp_end,
    input  logic [15:0] ramp_step,
    input  logic        fault_in,
    input  logic        clear_fault,
    input  logic        cycle_finished,
    output logic        pll_start,
    output logic        pll_halt,
    output logic [7:0]  phase_shift,
    output logic [15:0] cycle_limit,
    output logic        burst_active,
    output logic        burst_done,
    output logic        fault_latched,
    output logic [15:0] burst_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_START, S_RUN, S_DRAIN, S_HOLDOFF, S_FAULT
    } state_t;

    state_t      state_reg, state_next;
    logic        cf_d_reg, ext_d_reg;
    logic [23:0] rep_cnt_reg;
    logic [31:0] cnt_reg, wd_cnt_reg;
    logic [15:0] edge_cnt_reg, acc_reg, ramp_step_reg, cycle_limit_reg, burst_count_reg;
    logic [7:0]  ramp_end_reg, phase_reg;
    logic        burst_done_reg;

    logic        cf_rise, ext_rise, int_trig, trig;
    logic        last_edge, wd_expire, drain_done, holdoff_done;
    logic [15:0] edge_cnt_inc, acc_next;
    logic [16:0] sum17, limit17;

    assign cf_rise      = cycle_finished & ~cf_d_reg;
    assign ext_rise     = ext_trigger & ~ext_d_reg;
    assign int_trig     = (rep_cnt_reg == REP_PERIOD - 24'd1);
    assign trig         = trig_ext_sel ? ext_rise : int_trig;
    assign edge_cnt_inc = edge_cnt_reg + 16'd1;
    assign last_edge    = cf_rise && (edge_cnt_inc == cycle_limit_reg);
    assign wd_expire    = !cf_rise && (wd_cnt_reg == WATCHDOG_CYCLES - 1);
    assign drain_done   = (cnt_reg == DRAIN_CYCLES - 1);
    assign holdoff_done = (cnt_reg == HOLDOFF_CYCLES - 1);

    // 17-bit sum so a 0xFFFF overflow still saturates; a ramp_end below the
    // current value holds the accumulator instead of pulling it down.
    assign sum17   = {1'b0, acc_reg} + {1'b0, ramp_step_reg};
    assign limit17 = {1'b0, ramp_end_reg, 8'h00};
    assign acc_next = (sum17 >= limit17)
                    ? ((limit17[15:0] >= acc_reg) ? limit17[15:0] : acc_reg)
                    : sum17[15:0];

    always_comb begin
        state_next = state_reg;
        if (fault_in) begin
            state_next = S_FAULT;
        end else begin
            case (state_reg)
                S_IDLE:    if (enable) state_next = S_ARM;
                S_ARM: begin
                    if (!enable)   state_next = S_IDLE;
                    else if (trig) state_next = S_START;
                end
                S_START:   state_next = S_RUN;
                S_RUN: begin
                    if (last_edge)      state_next = S_DRAIN;
                    else if (wd_expire) state_next = S_FAULT;
                end
                S_DRAIN:   if (drain_done) state_next = S_HOLDOFF;
                S_HOLDOFF: if (holdoff_done) state_next = enable ? S_ARM : S_IDLE;
                S_FAULT:   if (clear_fault) state_next = S_HOLDOFF;
                default:   state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= S_IDLE;
            cf_d_reg        <= 1'b0;
            ext_d_reg       <= 1'b0;
            rep_cnt_reg     <= '0;
            cnt_reg         <= '0;
            wd_cnt_reg      <= '0;
            edge_cnt_reg    <= '0;
            acc_reg         <= '0;
            ramp_step_reg   <= '0;
            ramp_end_reg    <= '0;
            cycle_limit_reg <= '0;
            phase_reg       <= '0;
            burst_done_reg  <= 1'b0;
            burst_count_reg <= '0;
        end else begin
            state_reg <= state_next;
            cf_d_reg  <= cycle_finished;
            ext_d_reg <= ext_trigger;

            if (state_reg != S_FAULT)
                rep_cnt_reg <= int_trig ? 24'd0 : rep_cnt_reg + 24'd1;

            cnt_reg    <= (state_next != state_reg) ? 32'd0 : cnt_reg + 32'd1;
            wd_cnt_reg <= (state_reg == S_RUN && !cf_rise) ? wd_cnt_reg + 32'd1 : 32'd0;

            // Config is captured on the edge entering START so it is already valid
            // while pll_start is high.
            if (state_next == S_START) begin
                cycle_limit_reg <= (burst_cycles == 16'd0) ? 16'd1 : burst_cycles;
                acc_reg         <= {ramp_start, 8'h00};
                phase_reg       <= ramp_start;
                ramp_end_reg    <= ramp_end;
                ramp_step_reg   <= ramp_step;
                edge_cnt_reg    <= '0;
            end else if (state_reg == S_RUN && cf_rise) begin
                edge_cnt_reg <= edge_cnt_inc;
                acc_reg      <= acc_next;
                phase_reg    <= acc_next[15:8];
            end

            if (state_next == S_HOLDOFF || state_next == S_FAULT)
                phase_reg <= '0;

            burst_done_reg <= (state_reg == S_RUN) && (state_next == S_DRAIN);
            if (state_reg == S_DRAIN && state_next == S_HOLDOFF)
                burst_count_reg <= burst_count_reg + 16'd1;
        end
    end

    assign pll_start     = (state_reg == S_START);
    assign pll_halt      = (state_reg == S_FAULT);
    assign fault_latched = (state_reg == S_FAULT);
    assign burst_active  = (state_reg == S_START) || (state_reg == S_RUN) || (state_reg == S_DRAIN);
    assign burst_done    = burst_done_reg;
    assign phase_shift   = phase_reg;
    assign cycle_limit   = cycle_limit_reg;
    assign burst_count   = burst_count_reg;

endmodule

// File: tb/tb_qcw_burst_sequencer.sv
// Directed bench for qcw_burst_sequencer with a behavioural bridge-driver model
// that pulses cycle_finished every 363 clocks after each start.
module tb_qcw_burst_sequencer;

    localparam int unsigned HOLD = 200;
    localparam int unsigned DRN  = 20;
    localparam int unsigned WDOG = 400;
    localparam int unsigned REP  = 1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        trig_ext_sel = 1'b1;
    logic        ext_trigger = 1'b0;
    logic [15:0] burst_cycles = 16'd5;
    logic [7:0]  ramp_start = 8'h20;
    logic [7:0]  ramp_end = 8'h80;
    logic [15:0] ramp_step = 16'h1000;
    logic        fault_in = 1'b0;
    logic        clear_fault = 1'b0;
    logic        cycle_finished = 1'b0;
    logic        pll_start, pll_halt, burst_active, burst_done, fault_latched;
    logic [7:0]  phase_shift;
    logic [15:0] cycle_limit, burst_count;

    qcw_burst_sequencer #(
        .HOLDOFF_CYCLES(HOLD), .DRAIN_CYCLES(DRN),
        .WATCHDOG_CYCLES(WDOG), .REP_PERIOD(24'(REP))
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .trig_ext_sel(trig_ext_sel),
        .ext_trigger(ext_trigger), .burst_cycles(burst_cycles), .ramp_start(ramp_start),
        .ramp_end(ramp_end), .ramp_step(ramp_step), .fault_in(fault_in),
        .clear_fault(clear_fault), .cycle_finished(cycle_finished), .pll_start(pll_start),
        .pll_halt(pll_halt), .phase_shift(phase_shift), .cycle_limit(cycle_limit),
        .burst_active(burst_active), .burst_done(burst_done),
        .fault_latched(fault_latched), .burst_count(burst_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    int cyc = 0;
    int n_start = 0, n_done = 0;
    int t_start = 0, t_start_prev = 0, t_done = 0, t_fault = 0;
    int ph_log[16];
    int ph_n = 0, ph_last = 0;
    int done_edge = 0;
    logic fault_prev = 1'b0;

    // Driver model state
    int drv_timer = 0, drv_cnt = 0, drv_max = 100, t_edge3 = 0;
    bit drv_run = 0, fault_on_last = 0;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (pll_start) begin
                n_start++;
                t_start_prev = t_start;
                t_start = cyc;
                ph_n = 1;
                ph_log[0] = int'(phase_shift);
                ph_last = int'(phase_shift);
            end else if (burst_active && int'(phase_shift) != ph_last && ph_n < 16) begin
                ph_log[ph_n] = int'(phase_shift);
                ph_n++;
                ph_last = int'(phase_shift);
            end
            if (burst_done) begin
                n_done++;
                t_done = cyc;
                done_edge = drv_cnt;
            end
            if (fault_latched && !fault_prev) t_fault = cyc;
            fault_prev = fault_latched;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (pll_halt) begin
                drv_run = 0;
                cycle_finished = 1'b0;
            end else if (pll_start) begin
                drv_run = 1;
                drv_cnt = 0;
                drv_timer = 0;
                cycle_finished = 1'b0;
            end else if (drv_run) begin
                drv_timer++;
                if (drv_timer == 363) begin
                    cycle_finished = 1'b1;
                    drv_cnt++;
                    drv_timer = 0;
                    if (drv_cnt == 3) t_edge3 = cyc + 1;
                    if (drv_cnt == drv_max) begin
                        drv_run = 0;
                        if (fault_on_last) fault_in = 1'b1;
                    end
                end else if (drv_timer == 10) begin
                    cycle_finished = 1'b0;
                end
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_trig();
        ext_trigger = 1'b1;
        tick(1);
        ext_trigger = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_fault = 1'b1;
        tick(1);
        clear_fault = 1'b0;
    endtask

    task automatic wait_burst_end(input string tag, input int budget);
        bit seen = 0;
        bit ended = 0;
        for (int i = 0; i < budget && !ended; i++) begin
            tick(1);
            if (burst_active) seen = 1;
            else if (seen) ended = 1;
        end
        if (!ended) check_eq(tag, 0, 1);
    endtask

    initial begin
        // Reset state
        tick(3);
        check_eq("rst_pll_start", int'(pll_start), 0);
        check_eq("rst_pll_halt", int'(pll_halt), 0);
        check_eq("rst_phase", int'(phase_shift), 0);
        check_eq("rst_cycle_limit", int'(cycle_limit), 0);
        check_eq("rst_burst_count", int'(burst_count), 0);
        rst_n = 1'b1;
        tick(2);

        // Burst length and ramp
        enable = 1'b1;
        tick(5);
        check_eq("arm_no_start", n_start, 0);
        pulse_trig();
        tick(2);
        check_eq("t1_cycle_limit", int'(cycle_limit), 5);
        wait_burst_end("t1_timeout", 5000);
        check_eq("t1_starts", n_start, 1);
        check_eq("t1_ph_n", ph_n, 6);
        for (int i = 0; i < 6; i++)
            check_eq($sformatf("t1_ph%0d", i), ph_log[i], 32 + 16 * i);
        check_eq("t1_done_cnt", n_done, 1);
        check_eq("t1_done_edge", done_edge, 5);
        check_eq("t1_burst_count", int'(burst_count), 1);
        check_eq("t1_holdoff_phase", int'(phase_shift), 0);
        tick(10);
        pulse_trig();
        tick(300);
        check_eq("holdoff_trig_ignored", n_start, 1);

        // Saturation
        ramp_step = 16'h4000;
        burst_cycles = 16'd10;
        pulse_trig();
        wait_burst_end("t2_timeout", 6000);
        check_eq("t2_cycle_limit", int'(cycle_limit), 10);
        check_eq("t2_ph_n", ph_n, 3);
        check_eq("t2_ph1", ph_log[1], 'h60);
        check_eq("t2_ph2", ph_log[2], 'h80);
        check_eq("t2_burst_count", int'(burst_count), 2);
        tick(250);

        // Watchdog
        ramp_step = 16'h1000;
        burst_cycles = 16'd5;
        drv_max = 3;
        pulse_trig();
        for (int i = 0; i < 3000 && !fault_latched; i++) tick(1);
        check_eq("wd_fault", int'(fault_latched), 1);
        check_eq("wd_delay", t_fault - t_edge3, WDOG);
        check_eq("wd_halt", int'(pll_halt), 1);
        check_eq("wd_phase", int'(phase_shift), 0);
        check_eq("wd_active", int'(burst_active), 0);
        check_eq("wd_burst_count", int'(burst_count), 2);
        pulse_clear();
        check_eq("wd_cleared", int'(fault_latched), 0);
        drv_max = 100;
        tick(250);
        pulse_trig();
        tick(3);
        check_eq("wd_rearm_start", n_start, 4);
        wait_burst_end("t3_timeout", 5000);
        check_eq("t3_burst_count", int'(burst_count), 3);
        tick(250);

        // Fault priority over the final edge
        drv_max = 5;
        fault_on_last = 1;
        pulse_trig();
        for (int i = 0; i < 5000 && !fault_latched; i++) tick(1);
        fault_on_last = 0;
        check_eq("fp_fault", int'(fault_latched), 1);
        check_eq("fp_no_done", n_done, 3);
        tick(30);
        check_eq("fp_burst_count", int'(burst_count), 3);
        pulse_clear();
        tick(1);
        check_eq("fp_clear_ignored", int'(fault_latched), 1);
        fault_in = 1'b0;
        tick(2);
        pulse_clear();
        check_eq("fp_cleared", int'(fault_latched), 0);
        drv_max = 100;
        tick(250);

        // Internal trigger spacing
        burst_cycles = 16'd1;
        trig_ext_sel = 1'b0;
        for (int i = 0; i < 4000 && n_start < 7; i++) tick(1);
        trig_ext_sel = 1'b1;
        check_eq("int_starts", n_start, 7);
        check_eq("int_spacing_mod", (t_start - t_start_prev) % REP, 0);
        check_eq("int_holdoff_ok", int'((t_start - t_done) >= int'(HOLD + DRN)), 1);
        wait_burst_end("t5_timeout", 2000);
        tick(250);
        check_eq("t5_burst_count", int'(burst_count), 5);

        // Asynchronous reset mid-burst
        burst_cycles = 16'd5;
        pulse_trig();
        tick(380);
        check_eq("rb_run_phase", int'(phase_shift), 'h30);
        rst_n = 1'b0;
        #1;
        check_eq("rb_async_phase", int'(phase_shift), 0);
        check_eq("rb_async_limit", int'(cycle_limit), 0);
        check_eq("rb_async_active", int'(burst_active), 0);
        check_eq("rb_async_count", int'(burst_count), 0);
        tick(2);
        rst_n = 1'b1;
        tick(50);
        check_eq("rb_no_start", n_start, 8);
        pulse_trig();
        tick(2);
        check_eq("rb_new_start", n_start, 9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/qcw_burst_sequencer.md
Name: qcw_burst_sequencer

Overview:
- Sequences the QCW phase-locked bridge driver through one burst at a time: arm, start, per-cycle phase ramp, drain, holdoff, repeat.
- Drives the driver's start, halt, phase_shift and cycle_limit inputs and consumes its cycle_finished output.
- Sits between the host/config register bank and the PLL driver.
- Enforces a minimum off-time between bursts and latches faults.

Parameters:
- HOLDOFF_CYCLES, 500000: minimum clocks from end of DRAIN to next ARM.
- DRAIN_CYCLES, 2000: clocks waited after the last counted cycle so the driver returns to idle.
- WATCHDOG_CYCLES, 4000: maximum clocks between cycle_finished rising edges in RUN before a fault.
- REP_PERIOD, 2000000: internal trigger period in clocks, 24-bit.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  level; 0 returns the block to IDLE after the current burst drains
- trig_ext_sel  in  1  1 = use ext_trigger, 0 = use internal REP_PERIOD timer
- ext_trigger  in  1  external trigger, rising-edge sensitive
- burst_cycles  in  16  bridge cycles per burst; 0 is treated as 1
- ramp_start  in  8  phase_shift at burst start
- ramp_end  in  8  phase_shift saturation value
- ramp_step  in  16  unsigned 8.8 increment added per driver cycle
- fault_in  in  1  external fault (OCD etc.), level
- clear_fault  in  1  pulse; leaves FAULT
- cycle_finished  in  1  from driver
- pll_start  out  1  one-clock start pulse to driver
- pll_halt  out  1  halt to driver
- phase_shift  out  8  to driver
- cycle_limit  out  16  to driver
- burst_active  out  1  high in START, RUN, DRAIN
- burst_done  out  1  one-clock pulse on RUN→DRAIN
- fault_latched  out  1  high in FAULT
- burst_count  out  16  completed bursts; wraps at 0xFFFF→0

Behaviour:
- Reset values:
  - All outputs 0 except phase_shift = 0 and cycle_limit = 0.
  - State IDLE, accumulators cleared.
- States: IDLE, ARM, START, RUN, DRAIN, HOLDOFF, FAULT.
- IDLE → ARM when enable = 1.
- ARM:
  - Waits for a trigger: an ext_trigger rising edge if trig_ext_sel = 1, else the internal timer reaching REP_PERIOD−1.
  - The internal timer runs freely in every state except FAULT and resets to 0 on each internal trigger.
  - A trigger that occurs outside ARM is discarded; it is not queued.
  - enable = 0 in ARM → IDLE.
- START (exactly 1 clock):
  - pll_start = 1.
  - Latch cycle_limit = max(burst_cycles, 1).
  - Phase accumulator = {ramp_start, 8'h00}.
  - phase_shift = ramp_start.
  - Edge counter = 0.
  - Next state RUN.
- RUN:
  - cycle_finished is edge-detected with a 1-clock delay register; only rising edges count, because the level can remain high after the driver stops.
  - On each edge:
    - edge counter +1.
    - Accumulator += ramp_step in 17 bits, saturating at {ramp_end, 8'h00} (ramp_end < ramp_start: accumulator is held at ramp_start).
    - phase_shift = accumulator[15:8] on the following clock.
  - When edge counter reaches cycle_limit: burst_done pulse, → DRAIN.
  - Watchdog counter clears on each edge; reaching WATCHDOG_CYCLES → FAULT.
- DRAIN:
  - Count DRAIN_CYCLES, then burst_count +1 → HOLDOFF.
  - phase_shift holds its last value.
- HOLDOFF:
  - Count HOLDOFF_CYCLES, then → ARM if enable, else → IDLE.
  - phase_shift returns to 0 on entry.
- FAULT:
  - Entered from any state when fault_in = 1; this has priority over every other transition in the same clock.
  - Also entered on watchdog expiry.
  - pll_halt = 1, fault_latched = 1, phase_shift = 0, burst_active = 0.
  - Exit only on clear_fault = 1 with fault_in = 0, to HOLDOFF so the off-time is enforced.
  - clear_fault while fault_in = 1 is ignored.
- enable falling mid-burst:
  - Does not abort the burst; the sequence completes RUN/DRAIN/HOLDOFF, then → IDLE.
- Simultaneous events:
  - A cycle_finished edge arriving on the same clock the count is reached is counted once.
  - fault_in beats burst_done: no burst_done pulse and no burst_count increment.
- Config inputs are sampled only in START; changes during a burst take effect on the next burst.
- Width rules:
  - The accumulator sum uses a 17-bit intermediate, so saturation is exact at 0xFFFF overflow.
  - burst_count wraps.

Test Plan:
- Burst length and ramp: enable = 1, trig_ext_sel = 1, burst_cycles = 5, ramp_start = 0x20, ramp_end = 0x80, ramp_step = 0x1000, driver model pulsing cycle_finished every 363 clk, one ext_trigger.
  - Expect exactly one pll_start pulse and cycle_limit = 5.
  - phase_shift sequence 0x20, 0x30, 0x40, 0x50, 0x60, 0x70.
  - burst_done on the 5th edge; burst_count = 1 after DRAIN.
- Saturation: same setup with ramp_step = 0x4000 and burst_cycles = 10 → phase_shift reaches 0x80 on edge 2 and holds 0x80 through edge 10.
- Watchdog: driver model stops after 3 edges → FAULT exactly WATCHDOG_CYCLES clocks after edge 3.
  - pll_halt = 1, fault_latched = 1, phase_shift = 0.
  - clear_fault → HOLDOFF, then ARM.
- Trigger spacing: internal mode with REP_PERIOD = 100000 and HOLDOFF_CYCLES = 500000 → consecutive pll_start pulses are spaced by a multiple of 100000 clocks and never less than HOLDOFF_CYCLES + DRAIN_CYCLES after the previous burst_done.
  - Extra ext_trigger pulses during HOLDOFF produce no start.
- Fault priority: fault_in asserted on the same clock as the final cycle_finished edge → no burst_done, burst_count unchanged, FAULT entered.
  - clear_fault with fault_in still high → remains in FAULT.
- Reset mid-burst: rst_n low during RUN → outputs return to reset values asynchronously, before the next clk edge.
  - After release with enable = 1 → ARM, and no pll_start until a new trigger.
